// File: rtl/regfile_wb_ctrl.sv
// Write-port controller: arbitrates execute and load writebacks onto the register file
// write port and tracks pending load destinations. Build option: WB_STARVE_GUARD_EN.
module regfile_wb_ctrl #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_valid,
  input  logic [5:0]  pipe_addr,
  input  logic [31:0] pipe_data,
  output logic        pipe_ready,
  input  logic        ld_valid,
  input  logic [5:0]  ld_addr,
  input  logic [31:0] ld_data,
  output logic        ld_ready,
  input  logic        issue_en,
  input  logic [5:0]  issue_addr,
  input  logic [5:0]  rs1_addr,
  input  logic [5:0]  rs2_addr,
  output logic        rs1_busy,
  output logic        rs2_busy,
  output logic [4:0]  pending_cnt,
  output logic        wb_en,
  output logic [5:0]  wb_addr,
  output logic [31:0] write_data
);

  function automatic logic is_null(input logic [5:0] addr);
    return addr[5] || (addr[4:0] == 5'd0);
  endfunction

  logic        w_ld_pri;
  logic        w_pipe_xfer;
  logic        w_ld_xfer;

  assign pipe_ready  = !w_ld_pri;
  assign ld_ready    = w_ld_pri || !pipe_valid;
  assign w_pipe_xfer = pipe_valid && pipe_ready;
  assign w_ld_xfer   = ld_valid && ld_ready;

`ifdef WB_STARVE_GUARD_EN
  typedef enum logic {PIPE_PRI, LD_PRI} state_t;

  state_t     r_state, w_state_next;
  logic [3:0] r_starve_cnt, w_starve_cnt_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= PIPE_PRI;
      r_starve_cnt <= 4'd0;
    end else begin
      r_state      <= w_state_next;
      r_starve_cnt <= w_starve_cnt_next;
    end
  end

  // Switching on the post-increment count grants the load on the cycle right after its last refusal.
  always_comb begin
    w_state_next      = r_state;
    w_starve_cnt_next = r_starve_cnt;
    case (r_state)
      PIPE_PRI: begin
        if (w_ld_xfer) begin
          w_starve_cnt_next = 4'd0;
        end else if (ld_valid) begin
          w_starve_cnt_next = r_starve_cnt + 4'd1;
        end
        if (w_starve_cnt_next == 4'(STARVE_LIMIT)) begin
          w_state_next = LD_PRI;
        end
      end
      LD_PRI: begin
        if (w_ld_xfer || !ld_valid) begin
          w_state_next      = PIPE_PRI;
          w_starve_cnt_next = 4'd0;
        end
      end
      default: begin
        w_state_next      = PIPE_PRI;
        w_starve_cnt_next = 4'd0;
      end
    endcase
  end

  assign w_ld_pri = (r_state == LD_PRI);
`else
  logic [3:0] w_unused_limit;
  assign w_unused_limit = STARVE_LIMIT[3:0];
  assign w_ld_pri       = 1'b0;
`endif

  logic        r_wb_en;
  logic [5:0]  r_wb_addr;
  logic [31:0] r_write_data;
  logic        r_wb_from_ld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb_en      <= 1'b0;
      r_wb_addr    <= 6'd0;
      r_write_data <= 32'd0;
      r_wb_from_ld <= 1'b0;
    end else begin
      r_wb_en      <= 1'b0;
      r_wb_from_ld <= 1'b0;
      if (w_ld_xfer) begin
        r_wb_en      <= !is_null(ld_addr);
        r_wb_addr    <= ld_addr;
        r_write_data <= ld_data;
        r_wb_from_ld <= 1'b1;
      end else if (w_pipe_xfer) begin
        r_wb_en      <= !is_null(pipe_addr);
        r_wb_addr    <= pipe_addr;
        r_write_data <= pipe_data;
      end
    end
  end

  assign wb_en      = r_wb_en;
  assign wb_addr    = r_wb_addr;
  assign write_data = r_write_data;

  // Bit 0 is never set, so the array can be indexed directly by addr[4:0].
  logic [31:0] r_sb;
  logic [31:0] w_sb_next;
  logic [4:0]  r_pending_cnt;
  logic [4:0]  w_pending_next;

  always_comb begin
    w_sb_next = r_sb;
    if (r_wb_en && r_wb_from_ld) begin
      w_sb_next[r_wb_addr[4:0]] = 1'b0;
    end
    if (issue_en && !is_null(issue_addr)) begin
      w_sb_next[issue_addr[4:0]] = 1'b1;
    end
    w_sb_next[0] = 1'b0;
  end

  always_comb begin
    w_pending_next = 5'd0;
    for (int k = 1; k < 32; k++) begin
      w_pending_next = w_pending_next + 5'(w_sb_next[k]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sb          <= 32'd0;
      r_pending_cnt <= 5'd0;
    end else begin
      r_sb          <= w_sb_next;
      r_pending_cnt <= w_pending_next;
    end
  end

  assign pending_cnt = r_pending_cnt;
  assign rs1_busy    = !is_null(rs1_addr) && r_sb[rs1_addr[4:0]];
  assign rs2_busy    = !is_null(rs2_addr) && r_sb[rs2_addr[4:0]];

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Scoreboard bench for regfile_wb_ctrl: stimulus pushes expected writes, a monitor pops
// them on every wb_en cycle. Starvation expectations follow WB_STARVE_GUARD_EN.
module tb_regfile_wb_ctrl;

`ifdef WB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pipe_valid = 1'b0;
  logic [5:0]  pipe_addr = '0;
  logic [31:0] pipe_data = '0;
  logic        pipe_ready;
  logic        ld_valid = 1'b0;
  logic [5:0]  ld_addr = '0;
  logic [31:0] ld_data = '0;
  logic        ld_ready;
  logic        issue_en = 1'b0;
  logic [5:0]  issue_addr = '0;
  logic [5:0]  rs1_addr = '0;
  logic [5:0]  rs2_addr = '0;
  logic        rs1_busy, rs2_busy;
  logic [4:0]  pending_cnt;
  logic        wb_en;
  logic [5:0]  wb_addr;
  logic [31:0] write_data;

  regfile_wb_ctrl #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .pipe_valid(pipe_valid), .pipe_addr(pipe_addr), .pipe_data(pipe_data), .pipe_ready(pipe_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
    .issue_en(issue_en), .issue_addr(issue_addr),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .pending_cnt(pending_cnt), .wb_en(wb_en), .wb_addr(wb_addr), .write_data(write_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [5:0] a, input logic [31:0] d);
    exp_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every wb_en cycle must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst && wb_en) begin
      $display("wb addr=%0d data=%h", wb_addr, write_data);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_wb: got addr %0d expected no write", wb_addr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wb_addr", 32'(wb_addr), 32'(e.addr));
        chk("write_data", write_data, e.data);
      end
    end
  end

  int  p;
  bit  ld_pending;
  bit  ld_turn;

  initial begin
    #1;
    chk("rst_wb_en", 32'(wb_en), 0);
    chk("rst_wb_addr", 32'(wb_addr), 0);
    chk("rst_write_data", write_data, 0);
    chk("rst_pending_cnt", 32'(pending_cnt), 0);
    chk("rst_pipe_ready", 32'(pipe_ready), 1);
    chk("rst_ld_ready", 32'(ld_ready), 1);
    chk("rst_rs1_busy", 32'(rs1_busy), 0);
    step();
    rst = 1'b0;

    // Solo load write
    step();
    ld_valid = 1'b1; ld_addr = 6'd5; ld_data = 32'hDEADBEEF;
    #1 chk("solo_ld_ready", 32'(ld_ready), 1);
    push(6'd5, 32'hDEADBEEF);
    step();
    ld_valid = 1'b0;

    // Conflict: pipe first, then load
    step();
    pipe_valid = 1'b1; pipe_addr = 6'd3; pipe_data = 32'h0000_0033;
    ld_valid = 1'b1; ld_addr = 6'd4; ld_data = 32'h0000_0044;
    #1 chk("conf_pipe_ready", 32'(pipe_ready), 1);
    chk("conf_ld_ready", 32'(ld_ready), 0);
    push(6'd3, 32'h0000_0033);
    step();
    pipe_valid = 1'b0;
    #1 chk("conf_ld_ready2", 32'(ld_ready), 1);
    push(6'd4, 32'h0000_0044);
    step();
    ld_valid = 1'b0;

    // Starvation: pipe held valid, load waiting
    step();
    p = 0;
    ld_pending = 1'b1;
    pipe_valid = 1'b1;
    ld_addr = 6'd20; ld_data = 32'h0000_2020;
    for (int i = 0; i < 6; i++) begin
      pipe_addr = 6'(10 + p);
      pipe_data = 32'h1000 + 32'(p);
      ld_valid  = ld_pending;
      ld_turn   = GUARD && (i == 4);
      #1 chk("starve_pipe_ready", 32'(pipe_ready), 32'(!ld_turn));
      chk("starve_ld_ready", 32'(ld_ready), 32'(ld_turn));
      if (ld_turn) begin
        push(6'd20, 32'h0000_2020);
        ld_pending = 1'b0;
      end else begin
        push(6'(10 + p), 32'h1000 + 32'(p));
        p++;
      end
      step();
    end
    pipe_valid = 1'b0;
    ld_valid   = ld_pending;
    #1 chk("starve_release_ld_ready", 32'(ld_ready), 1);
    if (ld_pending) push(6'd20, 32'h0000_2020);
    step();
    ld_valid = 1'b0;

    // Scoreboard set / clear on load write
    step();
    issue_en = 1'b1; issue_addr = 6'd7; rs1_addr = 6'd7; rs2_addr = 6'd7;
    #1 chk("sb_busy_before", 32'(rs1_busy), 0);
    step();
    issue_en = 1'b0;
    #1 chk("sb_rs1_busy", 32'(rs1_busy), 1);
    chk("sb_rs2_busy", 32'(rs2_busy), 1);
    chk("sb_pending1", 32'(pending_cnt), 1);
    step();
    ld_valid = 1'b1; ld_addr = 6'd7; ld_data = 32'h0000_0777;
    push(6'd7, 32'h0000_0777);
    step();
    ld_valid = 1'b0;
    #1 chk("sb_busy_during_wb", 32'(rs1_busy), 1);
    step();
    #1 chk("sb_busy_after_wb", 32'(rs1_busy), 0);
    chk("sb_pending0", 32'(pending_cnt), 0);

    // Null destinations
    step();
    ld_valid = 1'b1; ld_addr = 6'd0; ld_data = 32'hBAD0_0000;
    issue_en = 1'b1; issue_addr = 6'd0;
    #1 chk("null0_ld_ready", 32'(ld_ready), 1);
    step();
    ld_addr = 6'h21; ld_data = 32'hBAD0_0021;
    issue_addr = 6'h27;
    #1 chk("null21_ld_ready", 32'(ld_ready), 1);
    step();
    ld_valid = 1'b0; issue_en = 1'b0;
    rs1_addr = 6'd0; rs2_addr = 6'd7;
    step();
    #1 chk("null_pending", 32'(pending_cnt), 0);
    chk("null_rs1_busy", 32'(rs1_busy), 0);
    chk("null_rs2_busy7", 32'(rs2_busy), 0);

    // Same-edge set and clear of bit 9, plus bit 12
    step();
    issue_en = 1'b1; issue_addr = 6'd9;
    step();
    issue_en = 1'b1; issue_addr = 6'd12;
    ld_valid = 1'b1; ld_addr = 6'd9; ld_data = 32'h0000_0999;
    push(6'd9, 32'h0000_0999);
    step();
    ld_valid = 1'b0;
    issue_en = 1'b1; issue_addr = 6'd9;
    step();
    issue_en = 1'b0;
    rs1_addr = 6'd9; rs2_addr = 6'h29;
    #1 chk("same_edge_busy9", 32'(rs1_busy), 1);
    chk("same_edge_null29", 32'(rs2_busy), 0);
    chk("same_edge_pending2", 32'(pending_cnt), 2);
    step();
    issue_en = 1'b1; issue_addr = 6'd12;
    step();
    issue_en = 1'b0;
    #1 chk("reissue_pending2", 32'(pending_cnt), 2);

    // Reset in the middle of a burst
    step();
    pipe_valid = 1'b1; pipe_addr = 6'd15; pipe_data = 32'h0000_0015;
    push(6'd15, 32'h0000_0015);
    step();
    pipe_addr = 6'd16; pipe_data = 32'h0000_0016;
    push(6'd16, 32'h0000_0016);
    step();
    pipe_addr = 6'd17; pipe_data = 32'h0000_0017;
    #5;
    rst = 1'b1;
    #1 chk("mid_rst_wb_en", 32'(wb_en), 0);
    chk("mid_rst_wb_addr", 32'(wb_addr), 0);
    chk("mid_rst_write_data", write_data, 0);
    chk("mid_rst_pending", 32'(pending_cnt), 0);
    chk("mid_rst_busy9", 32'(rs1_busy), 0);
    chk("mid_rst_pipe_ready", 32'(pipe_ready), 1);
    chk("mid_rst_queue", 32'(exp_q.size()), 0);
    exp_q.delete();
    pipe_valid = 1'b0;
    step();
    rst = 1'b0;

    step();
    ld_valid = 1'b1; ld_addr = 6'd30; ld_data = 32'h3030_3030;
    #1 chk("post_rst_ld_ready", 32'(ld_ready), 1);
    push(6'd30, 32'h3030_3030);
    step();
    ld_valid = 1'b0;

    for (int i = 0; i < 10; i++) begin
      if (exp_q.size() == 0) break;
      step();
    end
    step();
    chk("drain_queue_empty", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
